// File: rtl/pwm_hbridge_pkg.sv
`default_nettype none
// ============================================================================
// Module : pwm_hbridge_pkg
// Brief  : Shared types, direction codes and command helpers for the
//          multi-channel H-bridge PWM generator.
// Rev    : 1.0  initial release
// ============================================================================
package pwm_hbridge_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } ch_state_e;

    // Direction codes are {dir_a, dir_b}
    localparam logic [1:0] C_DIR_NONE = 2'b00;
    localparam logic [1:0] C_DIR_FWD  = 2'b10;
    localparam logic [1:0] C_DIR_REV  = 2'b01;

    function automatic logic [31:0] clamp_cmd(input logic [31:0] cmd, input logic [31:0] full);
        return (cmd > full) ? full : cmd;
    endfunction

    function automatic logic [31:0] cmd_mag(input logic [31:0] cmd, input logic [31:0] mid);
        return (cmd >= mid) ? (cmd - mid) : (mid - cmd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_hbridge_channel.sv
`default_nettype none
// ============================================================================
// Module : pwm_hbridge_channel
// Brief  : One H-bridge channel: shadowed command, direction FSM with
//          dead-time braking and registered pwm/dir outputs.
// Rev    : 1.0  initial release
// ============================================================================
module pwm_hbridge_channel
    import pwm_hbridge_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int PERIOD       = 256,
    parameter int DEAD_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_boundary,
    input  logic [CNT_W-1:0] i_cnt_nxt,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_duty_valid,
    output logic             o_pwm,
    output logic             o_dir_a,
    output logic             o_dir_b,
    output logic             o_dead
);

    localparam int               c_dcw       = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [c_dcw-1:0] c_dead_last = c_dcw'(DEAD_PERIODS - 1);
    localparam logic [CNT_W-1:0] c_mid       = CNT_W'(PERIOD);

    ch_state_e        r_state, w_state_nxt;
    logic [c_dcw-1:0] r_dcnt, w_dcnt_nxt;
    logic             r_hold, w_hold_nxt;
    logic [CNT_W-1:0] r_pending, r_active;
    logic [CNT_W-1:0] w_cmd, w_active_nxt, w_mag;
    logic             w_want_fwd, w_want_rev;
    logic [1:0]       w_dir;
    logic             r_pwm, r_dir_a, r_dir_b, r_dead;

    assign w_cmd        = CNT_W'(clamp_cmd(32'(i_duty), 32'(2 * PERIOD)));
    // A strobe landing on the boundary bypasses the shadow register
    assign w_active_nxt = i_boundary ? (i_duty_valid ? w_cmd : r_pending) : r_active;
    assign w_mag        = CNT_W'(cmd_mag(32'(w_active_nxt), 32'(PERIOD)));
    assign w_want_fwd   = (w_active_nxt > c_mid);
    assign w_want_rev   = (w_active_nxt < c_mid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= c_mid;
            r_active  <= c_mid;
        end else begin
            if (i_duty_valid) r_pending <= w_cmd;
            r_active <= w_active_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
            r_dcnt  <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // r_hold discards the partial period in which enable returned, so a
    // disable always yields DEAD_PERIODS complete periods of brake.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_hold_nxt  = r_hold;
        if (!i_enable) begin
            w_state_nxt = ST_DEAD;
            w_dcnt_nxt  = '0;
            w_hold_nxt  = 1'b1;
        end else if (i_boundary) begin
            case (r_state)
                ST_STOP: begin
                    if (w_want_fwd)      w_state_nxt = ST_FWD;
                    else if (w_want_rev) w_state_nxt = ST_REV;
                end
                ST_FWD: begin
                    if (!w_want_fwd) begin
                        w_state_nxt = ST_DEAD;
                        w_dcnt_nxt  = '0;
                        w_hold_nxt  = 1'b0;
                    end
                end
                ST_REV: begin
                    if (!w_want_rev) begin
                        w_state_nxt = ST_DEAD;
                        w_dcnt_nxt  = '0;
                        w_hold_nxt  = 1'b0;
                    end
                end
                ST_DEAD: begin
                    if (r_hold) begin
                        w_hold_nxt = 1'b0;
                    end else if (r_dcnt == c_dead_last) begin
                        w_dcnt_nxt = '0;
                        if (w_want_fwd)      w_state_nxt = ST_FWD;
                        else if (w_want_rev) w_state_nxt = ST_REV;
                        else                 w_state_nxt = ST_STOP;
                    end else begin
                        w_dcnt_nxt = r_dcnt + c_dcw'(1);
                    end
                end
                default: w_state_nxt = ST_STOP;
            endcase
        end
    end

    always_comb begin
        w_dir = C_DIR_NONE;
        case (w_state_nxt)
            ST_FWD:  w_dir = C_DIR_FWD;
            ST_REV:  w_dir = C_DIR_REV;
            default: w_dir = C_DIR_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm   <= 1'b0;
            r_dir_a <= 1'b0;
            r_dir_b <= 1'b0;
            r_dead  <= 1'b0;
        end else begin
            r_pwm   <= (w_dir != C_DIR_NONE) && (i_cnt_nxt < w_mag);
            r_dir_a <= w_dir[1];
            r_dir_b <= w_dir[0];
            r_dead  <= (w_state_nxt == ST_DEAD);
        end
    end

    a_dir_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(r_dir_a && r_dir_b));

    assign o_pwm   = r_pwm;
    assign o_dir_a = r_dir_a;
    assign o_dir_b = r_dir_b;
    assign o_dead  = r_dead;

endmodule
`default_nettype wire

// File: rtl/pwm_hbridge_multi.sv
`default_nettype none
// ============================================================================
// Module : pwm_hbridge_multi
// Brief  : Multi-channel signed PWM H-bridge driver with a shared period
//          counter, boundary-shadowed commands and enforced dead-time.
// Rev    : 1.0  initial release
// ============================================================================
module pwm_hbridge_multi
    import pwm_hbridge_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int PERIOD       = 256,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH*CNT_W-1:0] duty_in,
    input  logic [NUM_CH-1:0]       duty_valid,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH-1:0]       dir_a,
    output logic [NUM_CH-1:0]       dir_b,
    output logic [NUM_CH-1:0]       dead_active,
    output logic                    period_start
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(PERIOD - 1);

    generate
        if (DEAD_PERIODS < 1) begin : g_bad_dead
            $error("pwm_hbridge_multi: DEAD_PERIODS must be >= 1");
        end
        if (64'(2 * PERIOD) >= (64'(1) << CNT_W)) begin : g_bad_period
            $error("pwm_hbridge_multi: 2*PERIOD must fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_boundary;
    logic             r_period_start;

    assign w_boundary = (r_cnt == c_last);
    assign w_cnt_nxt  = w_boundary ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_period_start <= w_boundary;
        end
    end

    assign period_start = r_period_start;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_hbridge_channel #(
                .CNT_W        (CNT_W),
                .PERIOD       (PERIOD),
                .DEAD_PERIODS (DEAD_PERIODS)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_enable     (enable),
                .i_boundary   (w_boundary),
                .i_cnt_nxt    (w_cnt_nxt),
                .i_duty       (duty_in[gi*CNT_W +: CNT_W]),
                .i_duty_valid (duty_valid[gi]),
                .o_pwm        (pwm_out[gi]),
                .o_dir_a      (dir_a[gi]),
                .o_dir_b      (dir_b[gi]),
                .o_dead       (dead_active[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/pwm_hbridge_multi.md
Name: pwm_hbridge_multi

Overview:
Multi-channel successor to the single-channel signed PWM generator. Each channel takes an offset-binary command in which the midpoint means stop, above the midpoint means forward and below means reverse. Each channel drives one H-bridge through pwm/dir_a/dir_b. New behaviour:
- shared period counter across all channels
- shadow-register command update at period boundaries
- enforced dead-time (brake) on every direction change and on disable
- per-channel status outputs
Sits between the controller command registers and the motor driver pins.

Parameters:
NUM_CH, 4, number of independent H-bridge channels
CNT_W, 16, width of each command word and of the counter
PERIOD, 256, PWM period in clk cycles; full-scale command = 2*PERIOD, midpoint = PERIOD; must satisfy 2*PERIOD < 2^CNT_W
DEAD_PERIODS, 2, number of full PWM periods spent braking between directions; must be >= 1 (elaboration error otherwise)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  global drive enable; low forces all channels to brake
duty_in  in  NUM_CH*CNT_W  packed commands, channel i at [i*CNT_W +: CNT_W]
duty_valid  in  NUM_CH  per-channel strobe; captures the command into the pending register
pwm_out  out  NUM_CH  PWM enable per bridge
dir_a  out  NUM_CH  forward leg select
dir_b  out  NUM_CH  reverse leg select
dead_active  out  NUM_CH  high while the channel is in DEAD
period_start  out  1  one-cycle pulse in the cycle the counter is 0

Behaviour:
- Reset (async, rst_n=0): counter=0, pending=active=PERIOD, all channels in STOP, dead counters=0. All outputs 0 immediately, without waiting for clk.
- Counter: counts 0..PERIOD-1 and wraps. The "boundary" is the cycle in which counter==PERIOD-1. period_start is registered, high when counter==0.
- Command capture:
  - duty_valid[i]=1 → pending[i] <= min(duty_in slice, 2*PERIOD). The clamp is applied at capture.
  - At the boundary, active[i] <= pending[i].
  - If duty_valid coincides with the boundary, the newly presented value goes directly to active.
- Magnitude: mag = |active − PERIOD|, range 0..PERIOD. Desired direction: FWD if active>PERIOD, REV if active<PERIOD, NONE if equal.
- Per-channel FSM. Transitions are evaluated only at the boundary, except for the enable override.
  - STOP: dir=00, pwm=0. Desired FWD → FWD; desired REV → REV; desired NONE → stay.
  - FWD: dir=10. Desired FWD → stay; otherwise → DEAD with dead_cnt=0.
  - REV: dir=01. Desired REV → stay; otherwise → DEAD with dead_cnt=0.
  - DEAD: dir=00, pwm=0. At each boundary with enable=1, dead_cnt++.
    - When dead_cnt reaches DEAD_PERIODS−1 at a boundary, exit to the desired direction.
    - If desired is NONE at that point, exit to STOP.
- Enable override: enable=0 forces every channel to DEAD with dead_cnt=0 on the next clk, regardless of boundary. DEAD holds while enable=0. Counting resumes after re-enable, so at least DEAD_PERIODS full periods of brake always occur.
- Outputs are registered from the FSM state and counter:
  - pwm_out[i] = (state is FWD or REV) && (counter < mag).
  - mag=PERIOD gives 100% high; mag=0 gives constant low.
  - Latency: pwm/dir change one cycle after the boundary cycle; the first period under a new command starts with counter=0.
- dir_a and dir_b are never both 1; assert this in RTL.
- Counter and FSMs are unaffected by duty_valid outside boundaries; pending overwrites are last-write-wins.

Decomposition:
- Package pwm_hbridge_pkg holds:
  - channel state enum (STOP, FWD, REV, DEAD)
  - direction code constants
  - a clamp/magnitude helper function
- Top level holds the shared counter, boundary/period_start generation and enable fan-out.
- Sub-module pwm_hbridge_channel is instantiated NUM_CH times in a generate loop. It holds pending/active registers, the FSM, the dead counter and the output registers.

Test Plan:
Use NUM_CH=2, PERIOD=8, DEAD_PERIODS=2 throughout.
1. Reset: assert rst_n low mid-period → all outputs 0 within the same cycle, without a clock edge. Release → channels in STOP, period_start pulses every 8 cycles.
2. Forward command: duty_valid[0] with 12 → after the next boundary, dir_a[0]=1, dir_b[0]=0, pwm_out[0] high 4 of 8 cycles. Channel 1 stays 00/0.
3. Full scale and clamp: 16 → pwm high 8/8. 20 → identical to 16. 8 → FWD→DEAD for 2 periods, then STOP.
4. Reversal: 12 active, then 4 → dead_active=1 with dir=00 and pwm=0 for exactly 16 cycles, then dir_b=1, pwm 4/8.
5. Enable drop: enable low for 3 cycles mid-period while in FWD → next cycle dir=00, pwm=0. After re-enable, 2 full periods of DEAD, then FWD resumes.
6. Boundary race: duty_valid with 14 in the exact boundary cycle → the following period uses mag=6. A second write with 10 one cycle later takes effect one period after that.
